// File: rtl/router_pkg.sv
// Shared router definitions: byte/length widths, header field helpers and the
// drain-engine state encoding.
package router_pkg;

  localparam int DW     = 8;
  localparam int LEN_W  = 6;
  localparam int DLY_W  = 5;
  localparam int ADDR_W = 2;
  localparam int CNT_W  = LEN_W + 1;

  localparam logic [CNT_W-1:0] CNT_ONE = 7'd1;
  localparam logic [DLY_W-1:0] DLY_ONE = 5'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DLY   = 3'd1,
    ST_HDR   = 3'd2,
    ST_HWAIT = 3'd3,
    ST_BODY  = 3'd4,
    ST_DONE  = 3'd5
  } rd_state_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [DW-1:0] hdr);
    return hdr[7:2];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DW-1:0] hdr);
    return hdr[1:0];
  endfunction

  // Bytes still to come after the header: payload plus the parity byte.
  function automatic logic [CNT_W-1:0] hdr_cnt(input logic [DW-1:0] hdr);
    return {1'b0, hdr[7:2]} + CNT_ONE;
  endfunction

  function automatic logic par_zero(input logic [DW-1:0] acc);
    return (acc == 8'h00);
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR accumulator over a packet's bytes; shared by the source-side
// generator and the destination-side reader.
module router_parity_acc
  import router_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [DW-1:0] i_load_val,
  input  logic          i_xor_en,
  input  logic [DW-1:0] i_xor_val,
  output logic [DW-1:0] o_acc
);

  logic [DW-1:0] r_acc;

  // Clear beats load beats accumulate.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= 8'h00;
    end else if (i_clr) begin
      r_acc <= 8'h00;
    end else if (i_load) begin
      r_acc <= i_load_val;
    end else if (i_xor_en) begin
      r_acc <= r_acc ^ i_xor_val;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/router_pkt_reader.sv
// Destination-side drain engine: pulls header, payload and parity out of one
// router output FIFO, streams the bytes and reports one result per packet.
module router_pkt_reader
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic [DLY_W-1:0]  rd_delay,
  input  logic              fifo_empty,
  input  logic [DW-1:0]     fifo_dout,
  output logic              fifo_rd_en,
  output logic [DW-1:0]     byte_out,
  output logic              byte_valid,
  output logic              byte_last,
  output logic [ADDR_W-1:0] pkt_addr,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              len_err,
  output logic              pkt_abort,
  output logic              busy
);

  rd_state_t         r_state;
  logic [DLY_W-1:0]  r_dly_cnt;
  logic [CNT_W-1:0]  r_iss_cnt;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic              r_rd_pend;
  logic [DW-1:0]     r_byte_out;
  logic              r_byte_valid;
  logic              r_byte_last;
  logic [ADDR_W-1:0] r_pkt_addr;
  logic [LEN_W-1:0]  r_pkt_len;
  logic              r_pkt_done;
  logic              r_parity_err;
  logic              r_len_err;
  logic              r_pkt_abort;

  logic              w_rd_req;
  logic              w_rd_acc;
  logic              w_abort;
  logic              w_acc_load;
  logic              w_acc_xor;
  logic [DW-1:0]     w_acc;

  // Read request from state/counters only; the empty flag and resets gate it below.
  always_comb begin
    w_rd_req = 1'b0;
    case (r_state)
      ST_HDR:  w_rd_req = 1'b1;
      ST_BODY: w_rd_req = (r_iss_cnt != 7'd0);
      default: w_rd_req = 1'b0;
    endcase
  end

  assign w_rd_acc   = w_rd_req && !fifo_empty && rst && !soft_rst;
  assign w_abort    = soft_rst && (r_state != ST_IDLE);
  assign w_acc_load = (r_state == ST_HWAIT) && r_rd_pend;
  assign w_acc_xor  = (r_state == ST_BODY) && r_rd_pend;

  router_parity_acc u_par (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (soft_rst),
    .i_load     (w_acc_load),
    .i_load_val (fifo_dout),
    .i_xor_en   (w_acc_xor),
    .i_xor_val  (fifo_dout),
    .o_acc      (w_acc)
  );

  // Drain FSM with its counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_dly_cnt    <= 5'd0;
      r_iss_cnt    <= 7'd0;
      r_rx_cnt     <= 7'd0;
      r_rd_pend    <= 1'b0;
      r_byte_out   <= 8'h00;
      r_byte_valid <= 1'b0;
      r_byte_last  <= 1'b0;
      r_pkt_addr   <= 2'd0;
      r_pkt_len    <= 6'd0;
      r_pkt_done   <= 1'b0;
      r_parity_err <= 1'b0;
      r_len_err    <= 1'b0;
      r_pkt_abort  <= 1'b0;
    end else if (soft_rst) begin
      // Any read still in flight is dropped; the FIFO is flushed in the same cycle.
      r_state      <= ST_IDLE;
      r_dly_cnt    <= 5'd0;
      r_iss_cnt    <= 7'd0;
      r_rx_cnt     <= 7'd0;
      r_rd_pend    <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_last  <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_abort  <= w_abort;
    end else begin
      r_rd_pend    <= w_rd_acc;
      r_byte_valid <= 1'b0;
      r_byte_last  <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_abort  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fifo_empty) begin
            r_state <= ST_IDLE;
          end else if (rd_delay == 5'd0) begin
            r_state <= ST_HDR;
          end else begin
            r_dly_cnt <= rd_delay;
            r_state   <= ST_DLY;
          end
        end
        ST_DLY: begin
          r_dly_cnt <= r_dly_cnt - DLY_ONE;
          if (r_dly_cnt <= DLY_ONE) begin
            r_state <= ST_HDR;
          end else begin
            r_state <= ST_DLY;
          end
        end
        ST_HDR: begin
          if (w_rd_acc) begin
            r_state <= ST_HWAIT;
          end else begin
            r_state <= ST_HDR;
          end
        end
        ST_HWAIT: begin
          if (r_rd_pend) begin
            r_pkt_len    <= hdr_len(fifo_dout);
            r_pkt_addr   <= hdr_addr(fifo_dout);
            r_iss_cnt    <= hdr_cnt(fifo_dout);
            r_rx_cnt     <= hdr_cnt(fifo_dout);
            r_byte_out   <= fifo_dout;
            r_byte_valid <= 1'b1;
            r_state      <= ST_BODY;
          end else begin
            r_state <= ST_HWAIT;
          end
        end
        ST_BODY: begin
          if (w_rd_acc) begin
            r_iss_cnt <= r_iss_cnt - CNT_ONE;
          end else begin
            r_iss_cnt <= r_iss_cnt;
          end
          if (r_rd_pend) begin
            r_byte_out   <= fifo_dout;
            r_byte_valid <= 1'b1;
            r_rx_cnt     <= r_rx_cnt - CNT_ONE;
            if (r_rx_cnt == CNT_ONE) begin
              r_byte_last <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_BODY;
            end
          end else begin
            r_state <= ST_BODY;
          end
        end
        ST_DONE: begin
          r_pkt_done   <= 1'b1;
          r_parity_err <= !par_zero(w_acc);
          r_len_err    <= (r_pkt_len == 6'd0);
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_rd_en = w_rd_acc;
  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign byte_last  = r_byte_last;
  assign pkt_addr   = r_pkt_addr;
  assign pkt_len    = r_pkt_len;
  assign pkt_done   = r_pkt_done;
  assign parity_err = r_parity_err;
  assign len_err    = r_len_err;
  assign pkt_abort  = r_pkt_abort;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_router_pkt_reader.sv
// Randomised bench for router_pkt_reader: a FIFO model with 1-cycle read data
// feeds packets; expectations come from the packet bytes themselves.
module tb_router_pkt_reader;

  logic       clk = 1'b0;
  logic       rst, soft_rst;
  logic [4:0] rd_delay;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic [7:0] byte_out;
  logic       byte_valid, byte_last;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
  logic       pkt_done, parity_err, len_err, pkt_abort, busy;

  always #5 clk = ~clk;

  router_pkt_reader dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .rd_delay(rd_delay),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_last(byte_last),
    .pkt_addr(pkt_addr), .pkt_len(pkt_len), .pkt_done(pkt_done),
    .parity_err(parity_err), .len_err(len_err), .pkt_abort(pkt_abort), .busy(busy)
  );

  // FIFO model: bub[i] forces that many empty cycles after entry i is read.
  logic [7:0] mem [0:2047];
  int         bub [0:2047];
  int         wr_ptr = 0, rd_ptr = 0, bub_left = 0;

  assign fifo_empty = (rd_ptr == wr_ptr) || (bub_left != 0);

  always @(posedge clk) begin
    if (!rst || soft_rst) begin
      rd_ptr    <= wr_ptr;
      bub_left  <= 0;
      fifo_dout <= 8'h00;
    end else if (bub_left != 0) begin
      bub_left <= bub_left - 1;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr % 2048];
      bub_left  <= bub[rd_ptr % 2048];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int n_cmp = 0, n_err = 0;
  int n_acc = 0, n_bad = 0, n_abort = 0;
  int acc0 = 0, bad0 = 0, ab0 = 0;
  logic [8:0] got_q[$], exp_q[$];
  logic [9:0] done_q[$], expd_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (byte_valid) got_q.push_back({byte_last, byte_out});
    if (pkt_done) done_q.push_back({parity_err, len_err, pkt_addr, pkt_len});
    if (fifo_rd_en && !fifo_empty) n_acc++;
    if (fifo_rd_en && fifo_empty) n_bad++;
    if (pkt_abort) n_abort++;
  endtask

  function automatic logic [23:0] all_outs();
    return {fifo_rd_en, byte_valid, byte_last, pkt_done, parity_err, len_err,
            pkt_abort, busy, byte_out, pkt_addr, pkt_len};
  endfunction

  task automatic clear_bk();
    got_q.delete(); exp_q.delete(); done_q.delete(); expd_q.delete();
    acc0 = n_acc; bad0 = n_bad; ab0 = n_abort;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic last, input int bub_after);
    mem[wr_ptr % 2048] = b;
    bub[wr_ptr % 2048] = bub_after;
    exp_q.push_back({last, b});
    wr_ptr = wr_ptr + 1;
  endtask

  // Packet = header, len payload bytes, then XOR of everything before it (^ flip).
  task automatic gen_pkt(input logic [7:0] hdr, input logic [7:0] flip,
                         input int gap_pos, input int gap_len, input bit fixed);
    int         len;
    logic [7:0] x, b;
    logic [5:0] l6;
    logic [1:0] a2;
    len = int'(hdr) / 4;
    l6  = hdr[7:2];
    a2  = hdr[1:0];
    x   = hdr;
    push_byte(hdr, 1'b0, (gap_pos == 0) ? gap_len : 0);
    for (int i = 0; i < len; i++) begin
      b = fixed ? 8'((i + 1) * 17) : 8'($urandom);
      x = x ^ b;
      push_byte(b, 1'b0, (gap_pos == i + 1) ? gap_len : 0);
    end
    push_byte(x ^ flip, 1'b1, 0);
    expd_q.push_back({flip != 8'h00, len == 0, a2, l6});
  endtask

  task automatic drain(input string tag, input int npk);
    int t = 0;
    int nb;
    while (done_q.size() < npk && t < 3000) begin tick(); t++; end
    repeat (4) tick();
    check({tag, ":timeout"}, 32'(t < 3000), 32'd1);
    check({tag, ":n_done"}, done_q.size(), npk);
    check({tag, ":n_bytes"}, got_q.size(), exp_q.size());
    nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++) check($sformatf("%s:byte%0d", tag, i), got_q[i], exp_q[i]);
    for (int i = 0; i < done_q.size() && i < expd_q.size(); i++)
      check($sformatf("%s:result%0d", tag, i), done_q[i], expd_q[i]);
    check({tag, ":reads"}, n_acc - acc0, exp_q.size());
    check({tag, ":rd_when_empty"}, n_bad - bad0, 0);
    check({tag, ":no_abort"}, n_abort - ab0, 0);
    check({tag, ":idle"}, busy, 0);
    clear_bk();
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int t = 0;
    while (got_q.size() < n && t < 300) begin tick(); t++; end
    check({tag, ":reach_body"}, 32'(t < 300), 32'd1);
  endtask

  initial begin
    int k, npk, len;
    logic [7:0] hdr, flip;
    rst = 1'b0; soft_rst = 1'b0; rd_delay = 5'd0;
    repeat (3) tick();
    check("reset_outputs", all_outs(), 24'h0);
    rst = 1'b1;
    tick();
    clear_bk();

    gen_pkt(8'h0D, 8'h00, -1, 0, 1'b1);
    drain("t1_basic", 1);
    check("t1_pkt_len", pkt_len, 6'd3);
    check("t1_pkt_addr", pkt_addr, 2'd1);

    gen_pkt(8'h0D, 8'h01, -1, 0, 1'b1);
    drain("t2_bad_parity", 1);

    gen_pkt(8'h0D, 8'h00, 2, 3, 1'b1);
    drain("t3_bubble", 1);

    // rd_delay idle cycles must separate "FIFO non-empty seen" from the header read.
    rd_delay = 5'd5;
    gen_pkt(8'h0D, 8'h00, -1, 0, 1'b1);
    k = 0;
    tick();
    while (!fifo_rd_en && k < 100) begin k++; tick(); end
    check("t4_start_delay", k, 5);
    drain("t4_delay_pkt", 1);

    rd_delay = 5'd31;
    gen_pkt(8'h0D, 8'h00, -1, 0, 1'b1);
    repeat (10) tick();
    check("t4b_busy_in_dly", busy, 1);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("t4b_abort_pulse", pkt_abort, 1);
    check("t4b_busy_after", busy, 0);
    tick();
    check("t4b_abort_1cyc", pkt_abort, 0);
    repeat (40) tick();
    check("t4b_no_reads", n_acc - acc0, 0);
    check("t4b_abort_cnt", n_abort - ab0, 1);
    check("t4b_no_done", done_q.size(), 0);
    clear_bk();

    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    repeat (3) tick();
    check("idle_softrst_no_abort", n_abort - ab0, 0);
    clear_bk();

    rd_delay = 5'd0;
    gen_pkt(8'hFC, 8'h00, -1, 0, 1'b0);
    gen_pkt(8'h04, 8'h00, -1, 0, 1'b0);
    drain("t5_len63_b2b", 2);

    gen_pkt(8'h02, 8'h00, -1, 0, 1'b0);
    drain("t6_len0", 1);

    gen_pkt(8'h40, 8'h00, -1, 0, 1'b0);
    wait_bytes("t6b_rst", 4);
    rst = 1'b0;
    tick();
    check("t6b_reset_outputs", all_outs(), 24'h0);
    rst = 1'b1;
    tick();
    clear_bk();

    // soft_rst mid-body: pending byte discarded, delivered bytes are a clean prefix.
    gen_pkt(8'h41, 8'h00, -1, 0, 1'b0);
    wait_bytes("body_abort", 4);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("body_abort_pulse", pkt_abort, 1);
    check("body_abort_no_valid", byte_valid, 0);
    check("body_abort_busy", busy, 0);
    tick();
    check("body_abort_1cyc", pkt_abort, 0);
    repeat (5) tick();
    check("body_abort_no_done", done_q.size(), 0);
    for (int i = 0; i < got_q.size(); i++)
      check($sformatf("body_abort_prefix%0d", i), got_q[i], exp_q[i]);
    clear_bk();

    gen_pkt(8'h42, 8'h00, -1, 0, 1'b0);
    wait_bytes("rst_and_soft", 4);
    rst = 1'b0;
    soft_rst = 1'b1;
    tick();
    check("rst_wins_outputs", all_outs(), 24'h0);
    rst = 1'b1;
    soft_rst = 1'b0;
    tick();
    check("rst_wins_no_abort", n_abort - ab0, 0);
    clear_bk();

    for (int r = 0; r < 24; r++) begin
      rd_delay = 5'($urandom_range(0, 7));
      npk = $urandom_range(1, 2);
      for (int p = 0; p < npk; p++) begin
        hdr  = 8'($urandom);
        len  = int'(hdr) / 4;
        flip = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        gen_pkt(hdr, flip, $urandom_range(0, len), $urandom_range(0, 4), 1'b0);
      end
      drain($sformatf("rnd%0d", r), npk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
